// File: rtl/y86_seq_controller.sv
// Y86-64 sequential stage sequencer: one-hot stage enables,
// status register, memory handshake stall/timeout, perf counters.
module y86_seq_controller #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  input  logic [3:0]       icode,
  input  logic             valid_instruction,
  input  logic             valid_memory,
  input  logic             mem_ready,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             exec_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             pc_we,
  output logic             cc_we,
  output logic [2:0]       stage,
  output logic [2:0]       stat,
  output logic             busy,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DEC   = 3'd2,
    S_EXE   = 3'd3,
    S_MEM   = 3'd4,
    S_WB    = 3'd5,
    S_PCUPD = 3'd6,
    S_STOP  = 3'd7
  } state_t;

  localparam logic [2:0] ST_AOK = 3'd1;
  localparam logic [2:0] ST_HLT = 3'd2;
  localparam logic [2:0] ST_ADR = 3'd3;
  localparam logic [2:0] ST_INS = 3'd4;
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state, state_nx;
  logic [2:0] stat_q, stat_nx;
  logic [7:0] wait_q, wait_nx;
  logic       is_mem;

  always_comb begin
    is_mem = 1'b0;
    case (icode)
      4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: is_mem = 1'b1;
      default:                            is_mem = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      stat_q <= ST_AOK;
      wait_q <= '0;
    end else begin
      state  <= state_nx;
      stat_q <= stat_nx;
      wait_q <= wait_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    stat_nx   = stat_q;
    wait_nx   = '0;
    fetch_en  = 1'b0;
    decode_en = 1'b0;
    exec_en   = 1'b0;
    mem_en    = 1'b0;
    wb_en     = 1'b0;
    pc_we     = 1'b0;
    cc_we     = 1'b0;
    case (state)
      S_IDLE: begin
        if (step_mode ? step : start)
          state_nx = S_FETCH;
      end
      S_FETCH: begin
        fetch_en = 1'b1;
        if (!valid_memory) begin
          stat_nx  = ST_ADR;
          state_nx = S_STOP;
        end else if (!valid_instruction) begin
          stat_nx  = ST_INS;
          state_nx = S_STOP;
        end else if (icode == 4'h0) begin
          stat_nx  = ST_HLT;
          state_nx = S_STOP;
        end else begin
          state_nx = S_DEC;
        end
      end
      S_DEC: begin
        decode_en = 1'b1;
        state_nx  = S_EXE;
      end
      S_EXE: begin
        exec_en  = 1'b1;
        cc_we    = (icode == 4'h6);
        state_nx = S_MEM;
      end
      S_MEM: begin
        mem_en = 1'b1;
        if (!is_mem) begin
          state_nx = S_WB;
        end else if (mem_ready) begin
          if (!valid_memory) begin
            stat_nx  = ST_ADR;
            state_nx = S_STOP;
          end else begin
            state_nx = S_WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          // this is the last permitted wait cycle
          stat_nx  = ST_ADR;
          state_nx = S_STOP;
        end else begin
          wait_nx = wait_q + 8'd1;
        end
      end
      S_WB: begin
        wb_en    = 1'b1;
        state_nx = S_PCUPD;
      end
      S_PCUPD: begin
        pc_we = 1'b1;
        if (step_mode)  state_nx = S_IDLE;
        else if (start) state_nx = S_FETCH;
        else            state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_STOP;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      if (busy && cycle_count != '1)
        cycle_count <= cycle_count + 1'b1;
      if (state == S_PCUPD && instr_count != '1)
        instr_count <= instr_count + 1'b1;
    end
  end

  assign stage = state;
  assign stat  = stat_q;
  assign busy  = (state != S_IDLE) && (state != S_STOP);

endmodule

// File: tb/tb_y86_seq_controller.sv
// Scoreboard bench for y86_seq_controller: retire records are
// queued by stimulus and popped by a monitor on each pc_we.
module tb_y86_seq_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, step_mode, step;
  logic [3:0]  icode;
  logic        valid_instruction, valid_memory, mem_ready;
  logic        fetch_en, decode_en, exec_en, mem_en, wb_en, pc_we;
  logic        cc_we, busy;
  logic [2:0]  stage, stat;
  logic [31:0] cycle_count, instr_count;

  typedef struct {
    logic [31:0] ic;
    logic [31:0] cc;
  } rec_t;

  rec_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  y86_seq_controller #(.CNT_W(32), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .step_mode(step_mode), .step(step), .icode(icode),
    .valid_instruction(valid_instruction),
    .valid_memory(valid_memory), .mem_ready(mem_ready),
    .fetch_en(fetch_en), .decode_en(decode_en),
    .exec_en(exec_en), .mem_en(mem_en), .wb_en(wb_en),
    .pc_we(pc_we), .cc_we(cc_we), .stage(stage),
    .stat(stat), .busy(busy),
    .cycle_count(cycle_count), .instr_count(instr_count)
  );

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: per-cycle enable decode plus retire scoreboard
  always @(negedge clk) begin
    logic [5:0] en, en_exp;
    if (rst_n) begin
      en = {pc_we, wb_en, mem_en, exec_en, decode_en, fetch_en};
      en_exp = '0;
      if (stage >= 3'd1 && stage <= 3'd6)
        en_exp = 6'b1 << (stage - 3'd1);
      chk("enables", {58'd0, en}, {58'd0, en_exp});
      chk("cc_we", {63'd0, cc_we},
          {63'd0, (stage == 3'd3 && icode == 4'h6)});
      if (pc_we) begin
        if (sb.size() == 0) begin
          chk("unexpected_retire", 64'd1, 64'd0);
        end else begin
          rec_t r;
          r = sb.pop_front();
          chk("retire_instr", {32'd0, instr_count}, {32'd0, r.ic});
          chk("retire_cycle", {32'd0, cycle_count}, {32'd0, r.cc});
          chk("retire_stat", {61'd0, stat}, 64'd1);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_stage(input logic [2:0] s, input int max,
                            input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < max && !hit; i++) begin
      tick();
      if (stage == s) hit = 1'b1;
    end
    if (!hit) chk({"timeout_", name}, {61'd0, stage}, {61'd0, s});
  endtask

  task automatic pulse_step;
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    step_mode = 1'b0;
    step = 1'b0;
    icode = 4'h6;
    valid_instruction = 1'b1;
    valid_memory = 1'b1;
    mem_ready = 1'b1;
    repeat (2) tick();
    chk("rst_stage", {61'd0, stage}, 64'd0);
    chk("rst_stat", {61'd0, stat}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_cycles", {32'd0, cycle_count}, 64'd0);
    chk("rst_instr", {32'd0, instr_count}, 64'd0);
    rst_n = 1'b1;
    tick();

    // free-run, two OPq instructions
    sb.push_back('{ic: 32'd0, cc: 32'd5});
    sb.push_back('{ic: 32'd1, cc: 32'd11});
    start = 1'b1;
    repeat (7) tick();
    start = 1'b0;
    wait_stage(3'd0, 20, "run_idle");
    chk("run_instr", {32'd0, instr_count}, 64'd2);
    chk("run_cycles", {32'd0, cycle_count}, 64'd12);

    // single step, two NOPs
    step_mode = 1'b1;
    icode = 4'h1;
    sb.push_back('{ic: 32'd2, cc: 32'd17});
    pulse_step();
    wait_stage(3'd0, 20, "step1_idle");
    chk("step1_busy", {63'd0, busy}, 64'd0);
    chk("step1_instr", {32'd0, instr_count}, 64'd3);
    repeat (3) tick();
    chk("step1_hold", {61'd0, stage}, 64'd0);
    sb.push_back('{ic: 32'd3, cc: 32'd23});
    pulse_step();
    wait_stage(3'd0, 20, "step2_idle");
    chk("step2_instr", {32'd0, instr_count}, 64'd4);
    chk("step2_cycles", {32'd0, cycle_count}, 64'd24);

    // load with three stall cycles
    icode = 4'h5;
    mem_ready = 1'b0;
    sb.push_back('{ic: 32'd4, cc: 32'd32});
    pulse_step();
    wait_stage(3'd4, 10, "stall_mem");
    repeat (3) tick();
    chk("stall_still_mem", {61'd0, stage}, 64'd4);
    mem_ready = 1'b1;
    wait_stage(3'd0, 20, "stall_idle");
    chk("stall_instr", {32'd0, instr_count}, 64'd5);
    chk("stall_cycles", {32'd0, cycle_count}, 64'd33);

    // load that never completes
    mem_ready = 1'b0;
    pulse_step();
    wait_stage(3'd7, 40, "to_stop");
    chk("to_stat", {61'd0, stat}, 64'd3);
    chk("to_instr", {32'd0, instr_count}, 64'd5);
    chk("to_cycles", {32'd0, cycle_count}, 64'd51);
    chk("to_busy", {63'd0, busy}, 64'd0);

    // fetch fault: ADR beats INS
    do_reset();
    chk("rst2_stat", {61'd0, stat}, 64'd1);
    step_mode = 1'b0;
    icode = 4'h6;
    mem_ready = 1'b1;
    valid_memory = 1'b0;
    valid_instruction = 1'b0;
    start = 1'b1;
    wait_stage(3'd7, 10, "adr_stop");
    chk("adr_stat", {61'd0, stat}, 64'd3);
    chk("adr_cycles", {32'd0, cycle_count}, 64'd1);

    // halt, then start/step are ignored
    start = 1'b0;
    do_reset();
    valid_memory = 1'b1;
    valid_instruction = 1'b1;
    icode = 4'h0;
    start = 1'b1;
    wait_stage(3'd7, 10, "hlt_stop");
    chk("hlt_stat", {61'd0, stat}, 64'd2);
    step_mode = 1'b1;
    pulse_step();
    step_mode = 1'b0;
    repeat (3) tick();
    chk("hlt_sticky_stage", {61'd0, stage}, 64'd7);
    chk("hlt_sticky_stat", {61'd0, stat}, 64'd2);
    start = 1'b0;

    // async reset during a memory stall
    do_reset();
    icode = 4'h5;
    mem_ready = 1'b0;
    start = 1'b1;
    wait_stage(3'd4, 10, "ar_mem");
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_stage", {61'd0, stage}, 64'd0);
    chk("ar_stat", {61'd0, stat}, 64'd1);
    chk("ar_mem_en", {63'd0, mem_en}, 64'd0);
    chk("ar_cycles", {32'd0, cycle_count}, 64'd0);
    chk("ar_instr", {32'd0, instr_count}, 64'd0);
    start = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
